dmem_line_model: RTL and testbench

- Line-granular data memory that sits directly downstream of the data cache and services its miss refills and dirty-line write-backs.
- Every transfer is one 256-bit line (32 bytes), moved after a fixed, parameterised access latency.
- Handshake: requester holds enable high, and the block answers with a one-cycle ack pulse.
- Used in both the simulation top-level and the cache verification bench.

---
 rtl/dmem_line_model.sv | 121 ++++++++++++
 tb/tb_dmem_line_model.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_line_model.sv
// dmem_line_model: line-granular (256-bit) data memory behind the data cache.
// Each request is accepted in IDLE, waits a fixed LATENCY, then acks for one
// cycle followed by a mandatory turnaround cycle before the next acceptance.
// Optional per-direction completion counters are built when DMEM_STATS_EN is
// defined; without it the rd_cnt_o/wr_cnt_o ports do not exist.
module dmem_line_model #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]  rd_cnt_o,
    output logic [31:0]  wr_cnt_o
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    localparam logic [7:0] CntLoad = 8'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q;
    logic              write_q;
    logic [255:0]      wdata_q;
    logic              accept;
    logic              access;

    // Storage is intentionally never reset; contents are undefined until written.
    logic [255:0] mem [2**ADDR_W];

    // Byte offset and aliased upper address bits carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_W+5], addr_i[4:0]};

    assign accept = (state_q == StIdle) && enable_i;
    assign access = (state_q == StWait) && (cnt_q == 8'd0);

    // Next-state and latency countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StWait;
                    cnt_d   = CntLoad;
                end
            end
            StWait: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = StAck;
                end
            end
            // enable_i is deliberately ignored here to force a turnaround cycle.
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state, request latches, ack pulse and read-data register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ack_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= access;
            if (accept) begin
                idx_q   <= addr_i[ADDR_W+4:5];
                write_q <= write_i;
                wdata_q <= data_i;
            end
            if (access && !write_q) begin
                data_o <= mem[idx_q];
            end
        end
    end

    // Line write; a reset during WAIT forces IDLE so a pending write is dropped.
    always_ff @(posedge clk_i) begin
        if (access && write_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef DMEM_STATS_EN
    // Completion counters, stepped on the ack-issuing edge; wrap naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_cnt_o <= 32'd0;
            wr_cnt_o <= 32'd0;
        end else if (access) begin
            if (write_q) begin
                wr_cnt_o <= wr_cnt_o + 32'd1;
            end else begin
                rd_cnt_o <= rd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_line_model.sv
// Scoreboard bench for dmem_line_model: the driver pushes expected completions,
// a monitor pops and checks latency and data on every ack against a line model.
module tb_dmem_line_model;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned LATENCY = 10;
    localparam int unsigned NoAck   = 32'hFFFF_FFFF;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         ack_o;
    logic [255:0] data_o;
`ifdef DMEM_STATS_EN
    logic [31:0]  rd_cnt_o;
    logic [31:0]  wr_cnt_o;
`endif

    dmem_line_model #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o (rd_cnt_o),
        .wr_cnt_o (wr_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           w;
        int unsigned  idx;
        logic [255:0] data;
        int unsigned  ack_cyc;
    } exp_t;

    exp_t         sbq[$];
    logic [255:0] model [int unsigned];
    logic [255:0] last_rd;
    bit           last_rd_known;
    int unsigned  cyc;
    int unsigned  last_ack_cyc;
    int unsigned  ack_count;
    int unsigned  n_rd;
    int unsigned  n_wr;
    int           checks;
    int           errors;

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Posedge counter; the monitor and driver read it between edges.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    // Monitor: every ack must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i && ack_o) begin
                ack_count++;
                last_ack_cyc = cyc;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: ack_o=1 at cycle %0d, required no ack", cyc);
                end else begin
                    e = sbq.pop_front();
                    if (cyc != e.ack_cyc) begin
                        errors++;
                        $display("FAIL ack_latency: ack at cycle %0d, required %0d", cyc, e.ack_cyc);
                    end
                    if (e.w) begin
                        model[e.idx] = e.data;
                        n_wr++;
                    end else begin
                        n_rd++;
                        last_rd_known = model.exists(e.idx);
                        if (last_rd_known) last_rd = model[e.idx];
                    end
                    if (last_rd_known) begin
                        checks++;
                        if (data_o !== last_rd) begin
                            errors++;
                            $display("FAIL data_o (%s line %0d): got %h, required %h",
                                     e.w ? "write" : "read", e.idx, data_o, last_rd);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_i);
            #1;
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        last_rd       = '0;
        last_rd_known = 1'b1;
        last_ack_cyc  = NoAck;
        n_rd          = 0;
        n_wr          = 0;
    endtask

    // Issue one request (called just after a negedge) and wait for its ack.
    // If the previous ack edge was the last edge, the DUT is in its turnaround.
    // drop_early models a requester that releases enable while the access waits.
    task automatic request(input bit w, input logic [31:0] a, input logic [255:0] d,
                           input bit drop_early);
        int unsigned acc;
        int unsigned start_cnt;
        int          n;
        acc = (last_ack_cyc == cyc) ? cyc + 2 : cyc + 1;
        enable_i = 1'b1;
        write_i  = w;
        addr_i   = a;
        data_i   = d;
        sbq.push_back('{w, (a >> 5) % (1 << ADDR_W), d, acc + LATENCY});
        start_cnt = ack_count;
        n = 0;
        while (ack_count == start_cnt && n < int'(LATENCY) + 20) begin
            step(1);
            n++;
            if (drop_early && n == 3) enable_i = 1'b0;
        end
        if (ack_count == start_cnt) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack after %0d cycles, required ack at cycle %0d",
                     n, acc + LATENCY);
            sbq.delete();
        end
    endtask

    task automatic idle(input int n);
        enable_i = 1'b0;
        step(n);
    endtask

    task automatic check_counts();
`ifdef DMEM_STATS_EN
        checks++;
        if (rd_cnt_o !== n_rd || wr_cnt_o !== n_wr) begin
            errors++;
            $display("FAIL stats: rd_cnt_o=%0d wr_cnt_o=%0d, required rd=%0d wr=%0d",
                     rd_cnt_o, wr_cnt_o, n_rd, n_wr);
        end
`endif
    endtask

    initial begin
        logic [255:0] pat_a;
        logic [255:0] pat_b;
        logic [255:0] pat_c;
        logic [255:0] pat_d;
        int unsigned  first_ack;
        int unsigned  acks_before;
        bit           w;
        logic [31:0]  a;

        checks = 0;
        errors = 0;
        ack_count = 0;
        model_reset();
        pat_a = rnd256();
        pat_b = rnd256();
        pat_c = rnd256();
        pat_d = rnd256();

        // Reset state.
        step(3);
        checks++;
        if (ack_o !== 1'b0 || data_o !== '0) begin
            errors++;
            $display("FAIL reset_state: ack_o=%b data_o=%h, required 0 and 0", ack_o, data_o);
        end
        check_counts();
        rst_i = 1'b1;
        step(2);

        // Write then read one line.
        request(1'b1, 32'h0000_0040, {8{32'hDEAD_BEEF}}, 1'b0);
        idle(1);
        request(1'b0, 32'h0000_0040, '0, 1'b0);
        idle(2);

        // Back-to-back with enable held: write_i drops on the ack edge.
        request(1'b1, 32'h0000_0400, pat_a, 1'b0);
        first_ack = last_ack_cyc;
        request(1'b0, 32'h0000_0400, '0, 1'b0);
        checks++;
        if (last_ack_cyc - first_ack != LATENCY + 2) begin
            errors++;
            $display("FAIL b2b_spacing: acks %0d edges apart, required %0d",
                     last_ack_cyc - first_ack, LATENCY + 2);
        end
        idle(1);

        // Byte offset ignored, upper bits alias.
        request(1'b1, 32'h0000_0065, pat_b, 1'b0);
        idle(1);
        request(1'b0, 32'h0000_0060, '0, 1'b0);
        idle(1);
        request(1'b0, 32'h0000_4060, '0, 1'b0);
        idle(1);

        // Enable released during WAIT still completes.
        request(1'b1, 32'h0000_0080, pat_c, 1'b1);
        idle(1);
        request(1'b0, 32'h0000_0080, '0, 1'b0);
        check_counts();

        // Async reset while ack is high: outputs clear immediately.
        rst_i = 1'b0;
        enable_i = 1'b0;
        #1;
        checks++;
        if (ack_o !== 1'b0 || data_o !== '0) begin
            errors++;
            $display("FAIL async_reset: ack_o=%b data_o=%h, required 0 and 0", ack_o, data_o);
        end
        model_reset();
        check_counts();
        step(2);
        rst_i = 1'b1;
        step(1);

        // Reset during WAIT discards the pending write to line 3.
        request(1'b1, 32'd3 << 5, pat_d, 1'b0);
        idle(2);
        acks_before = ack_count;
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'd3 << 5;
        data_i   = pat_c;
        step(6);
        rst_i = 1'b0;
        enable_i = 1'b0;
        model_reset();
        step(2);
        rst_i = 1'b1;
        step(int'(LATENCY) + 5);
        checks++;
        if (ack_count != acks_before) begin
            errors++;
            $display("FAIL reset_in_wait_ack: %0d acks seen, required 0",
                     ack_count - acks_before);
        end
        request(1'b0, 32'd3 << 5, '0, 1'b0);
        idle(1);

        // Randomised traffic over a small set of lines with aliasing addresses.
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 5)
                | 32'($urandom_range(0, 31));
            request(w, a, rnd256(), 1'b0);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(3);
        check_counts();

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL outstanding: %0d requests never acked, required 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
